// File: rtl/axi2mem_wr_cmd_seq.sv
// axi2mem_wr_cmd_seq
// Expands one AXI4 AW burst at a time into per-beat write commands
// (id, byte address, last) for the TCDM write interface.
// Optional feature macro: AXI2MEM_WRAP_BURST_EN
//   defined     -> WRAP bursts wrap within (len+1)<<size bytes
//   not defined -> WRAP (2'b10) is treated exactly like INCR
module axi2mem_wr_cmd_seq #(
    parameter int ID_WIDTH = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                aw_valid_i,
    output logic                aw_ready_o,
    input  logic [ID_WIDTH-1:0] aw_id_i,
    input  logic [31:0]         aw_addr_i,
    input  logic [7:0]          aw_len_i,
    input  logic [2:0]          aw_size_i,
    input  logic [1:0]          aw_burst_i,
    output logic                trans_req_o,
    input  logic                trans_gnt_i,
    output logic [ID_WIDTH-1:0] trans_id_o,
    output logic [31:0]         trans_add_o,
    output logic                trans_last_o,
    output logic                busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic        aw_hs;
    logic        advance;
`ifdef AXI2MEM_WRAP_BURST_EN
    logic [7:0]  len_q;
`endif

    // The data path is 32 bits wide, so beat sizes above 4 bytes saturate to 4.
    function automatic logic [2:0] sat_size(input logic [2:0] size);
        return (size > 3'd2) ? 3'd2 : size;
    endfunction

`ifdef AXI2MEM_WRAP_BURST_EN
    // Address of the following beat; WRAP keeps the upper bits of the wrap window.
    function automatic logic [31:0] next_addr(input logic [31:0] cur,
                                              input logic [2:0]  size,
                                              input logic [7:0]  len,
                                              input logic [1:0]  burst);
        logic [31:0] inc;
        logic [31:0] span;
        inc  = 32'd1 << size;
        span = ({24'd0, len} + 32'd1) << size;
        case (burst)
            2'b00:   return cur;
            2'b10:   return (cur & ~(span - 32'd1)) | ((cur + inc) & (span - 32'd1));
            default: return (cur & ~(inc - 32'd1)) + inc;
        endcase
    endfunction
`else
    // Address of the following beat; WRAP falls through to INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] cur,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [31:0] inc;
        inc = 32'd1 << size;
        case (burst)
            2'b00:   return cur;
            default: return (cur & ~(inc - 32'd1)) + inc;
        endcase
    endfunction
`endif

    assign aw_hs   = (state_q == IDLE) && aw_valid_i;
    assign advance = (state_q == BURST) && trans_gnt_i && (cnt_q != 8'd0);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept a burst in IDLE, leave BURST on the final grant
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (aw_valid_i) state_d = BURST;
            BURST:   if (trans_gnt_i && (cnt_q == 8'd0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and the beat counter
    always_comb begin
        aw_ready_o   = 1'b0;
        trans_req_o  = 1'b0;
        busy_o       = 1'b0;
        trans_last_o = 1'b0;
        case (state_q)
            IDLE: begin
                aw_ready_o = 1'b1;
            end
            BURST: begin
                trans_req_o  = 1'b1;
                busy_o       = 1'b1;
                trans_last_o = (cnt_q == 8'd0);
            end
            default: ;
        endcase
    end

    // Burst context: latch on AW handshake, step the address on each non-final grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= 8'd0;
            size_q      <= 3'd0;
            burst_q     <= 2'b00;
            trans_id_o  <= '0;
            trans_add_o <= 32'd0;
`ifdef AXI2MEM_WRAP_BURST_EN
            len_q       <= 8'd0;
`endif
        end else if (aw_hs) begin
            cnt_q       <= aw_len_i;
            size_q      <= sat_size(aw_size_i);
            burst_q     <= aw_burst_i;
            trans_id_o  <= aw_id_i;
            trans_add_o <= aw_addr_i;
`ifdef AXI2MEM_WRAP_BURST_EN
            len_q       <= aw_len_i;
`endif
        end else if (advance) begin
            cnt_q       <= cnt_q - 8'd1;
`ifdef AXI2MEM_WRAP_BURST_EN
            trans_add_o <= next_addr(trans_add_o, size_q, len_q, burst_q);
`else
            trans_add_o <= next_addr(trans_add_o, size_q, burst_q);
`endif
        end
    end

endmodule

// File: tb/tb_axi2mem_wr_cmd_seq.sv
// Scoreboard bench for axi2mem_wr_cmd_seq: the driver pushes the expected
// beat list of every accepted burst, a negedge monitor compares each
// presented beat against the queue head and pops it on grant.
module tb_axi2mem_wr_cmd_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        aw_valid_i;
    logic        aw_ready_o;
    logic [5:0]  aw_id_i;
    logic [31:0] aw_addr_i;
    logic [7:0]  aw_len_i;
    logic [2:0]  aw_size_i;
    logic [1:0]  aw_burst_i;
    logic        trans_req_o;
    logic        trans_gnt_i;
    logic [5:0]  trans_id_o;
    logic [31:0] trans_add_o;
    logic        trans_last_o;
    logic        busy_o;

    axi2mem_wr_cmd_seq #(.ID_WIDTH(6)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .aw_valid_i   (aw_valid_i),
        .aw_ready_o   (aw_ready_o),
        .aw_id_i      (aw_id_i),
        .aw_addr_i    (aw_addr_i),
        .aw_len_i     (aw_len_i),
        .aw_size_i    (aw_size_i),
        .aw_burst_i   (aw_burst_i),
        .trans_req_o  (trans_req_o),
        .trans_gnt_i  (trans_gnt_i),
        .trans_id_o   (trans_id_o),
        .trans_add_o  (trans_add_o),
        .trans_last_o (trans_last_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [5:0]  id;
        logic [31:0] addr;
        logic        last;
    } beat_t;

    beat_t sbq[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: list every beat address of a burst directly from its index.
    task automatic push_exp(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] inc, base, span, lower, a;
        int n;
        inc   = 32'd1 << ((size > 3'd2) ? 3'd2 : size);
        n     = int'(len) + 1;
        base  = addr - (addr % inc);
        span  = inc * 32'(n);
        lower = addr - (addr % span);
        for (int i = 0; i < n; i++) begin
            if (i == 0) a = addr;
            else if (burst == 2'b00) a = addr;
`ifdef AXI2MEM_WRAP_BURST_EN
            else if (burst == 2'b10) a = lower + (((addr - lower) + 32'(i) * inc) % span);
`endif
            else a = base + 32'(i) * inc;
            sbq.push_back(beat_t'{id: id, addr: a, last: (i == n - 1)});
        end
    endtask

    // Monitor: every presented beat must match the queue head; a grant retires it
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && trans_req_o === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("extra_beat", 32'(trans_add_o), 32'hFFFF_FFFF);
            end else begin
                chk("beat_addr", trans_add_o, sbq[0].addr);
                chk("beat_id", 32'(trans_id_o), 32'(sbq[0].id));
                chk("beat_last", 32'(trans_last_o), 32'(sbq[0].last));
                if (trans_gnt_i) void'(sbq.pop_front());
            end
        end
    end

    // Present an AW burst, wait (bounded) for acceptance, record expected beats.
    task automatic send_aw(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit keep_valid);
        int cyc = 0;
        aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_size_i = size; aw_burst_i = burst;
        aw_valid_i = 1'b1;
        @(negedge clk_i);
        while (aw_ready_o !== 1'b1 && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("aw_accept", 32'(aw_ready_o), 32'd1);
        push_exp(id, addr, len, size, burst);
        @(posedge clk_i); #1;
        if (!keep_valid) aw_valid_i = 1'b0;
    endtask

    // Grant beats: mode 0 always, 1 random, 2 stall beat 1 for two cycles.
    task automatic drain(input int len, input int mode);
        int left = len + 1;
        int beat = 0;
        int stalls = 0;
        int cyc = 0;
        logic g;
        while (left > 0 && cyc < 300) begin
            if (mode == 1) g = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && beat == 1 && stalls < 2) begin g = 1'b0; stalls++; end
            else g = 1'b1;
            trans_gnt_i = g;
            @(negedge clk_i);
            chk("burst_req", 32'(trans_req_o), 32'd1);
            chk("burst_awready", 32'(aw_ready_o), 32'd0);
            chk("burst_busy", 32'(busy_o), 32'd1);
            if (g) begin left--; beat++; end
            @(posedge clk_i); #1;
            cyc++;
        end
        trans_gnt_i = 1'b0;
        if (left > 0) chk("drain_timeout", 32'(left), 32'd0);
        @(negedge clk_i);
        chk("end_req", 32'(trans_req_o), 32'd0);
        chk("end_awready", 32'(aw_ready_o), 32'd1);
        chk("end_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_awready"}, 32'(aw_ready_o), 32'd1);
        chk({tag, "_req"}, 32'(trans_req_o), 32'd0);
        chk({tag, "_last"}, 32'(trans_last_o), 32'd0);
        chk({tag, "_id"}, 32'(trans_id_o), 32'd0);
        chk({tag, "_add"}, trans_add_o, 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [5:0]  rid;
        logic [31:0] raddr;
        logic [7:0]  rlen;
        logic [2:0]  rsize;
        logic [1:0]  rburst;
        rst_ni = 1'b0; aw_valid_i = 1'b0; trans_gnt_i = 1'b0;
        aw_id_i = '0; aw_addr_i = '0; aw_len_i = '0; aw_size_i = '0; aw_burst_i = '0;
        #1;
        chk_reset_vals("rst0");
        @(negedge clk_i); #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // directed cases
        send_aw(6'd5, 32'h0000_1000, 8'd3, 3'd2, 2'b01, 1'b0); drain(3, 0);
        send_aw(6'd9, 32'h0000_2001, 8'd2, 3'd2, 2'b01, 1'b0); drain(2, 0);
        send_aw(6'd17, 32'h0000_3008, 8'd2, 3'd1, 2'b00, 1'b0); drain(2, 2);
        send_aw(6'd33, 32'h0000_4018, 8'd3, 3'd2, 2'b10, 1'b0); drain(3, 0);
        send_aw(6'd2, 32'h0000_5000, 8'd1, 3'd3, 2'b01, 1'b0); drain(1, 0);
        send_aw(6'd63, 32'h0000_6002, 8'd0, 3'd1, 2'b01, 1'b0); drain(0, 0);
        send_aw(6'd7, 32'hFFFF_FFF8, 8'd3, 3'd2, 2'b11, 1'b0); drain(3, 1);

        // randomized bursts
        for (int k = 0; k < 40; k++) begin
            rid    = 6'($urandom);
            rburst = 2'($urandom);
            rsize  = 3'($urandom);
            raddr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                                 : $urandom;
            if (rburst == 2'b10) begin
                rlen  = 8'((1 << $urandom_range(1, 4)) - 1);
                raddr = raddr & ~((32'd1 << ((rsize > 3'd2) ? 3'd2 : rsize)) - 32'd1);
            end else begin
                rlen = 8'($urandom_range(0, 15));
            end
            send_aw(rid, raddr, rlen, rsize, rburst, 1'b0);
            drain(int'(rlen), 1);
        end

        // reset mid-burst with a second AW pending
        send_aw(6'd11, 32'h0000_7000, 8'd7, 3'd2, 2'b01, 1'b1);
        aw_id_i = 6'd12; aw_addr_i = 32'h0000_8004; aw_len_i = 8'd2; aw_size_i = 3'd2; aw_burst_i = 2'b01;
        trans_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("rb_awready_b0", 32'(aw_ready_o), 32'd0);
        @(posedge clk_i); #1;
        trans_gnt_i = 1'b0;
        chk("rb_awready_b1", 32'(aw_ready_o), 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        chk_reset_vals("rstmid");
        sbq.delete();
        @(negedge clk_i); #1 rst_ni = 1'b1;
        chk("rel_awready", 32'(aw_ready_o), 32'd1);
        push_exp(6'd12, 32'h0000_8004, 8'd2, 3'd2, 2'b01);
        @(posedge clk_i); #1;
        aw_valid_i = 1'b0;
        drain(2, 0);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
